dmem_pipe: RTL
==============

# dmem_pipe

Parametrised, pipelined data memory for the LSU bus. It replaces the fixed 32-bit, combinational-read data memory with a ready/valid request/response port, byte/half/word(/double) accesses with byte-lane writes, configurable read latency, and error responses for misaligned or out-of-range addresses. It sits on the LSU data bus beside the UART and other peripherals, selected by address decode in the LSU.

## Interface
Parameters:
- DATA_W, 32: memory word width; 32 or 64 only.
- DEPTH, 512: number of DATA_W-bit words.
- ADDR_W, 32: byte-address width.
- BASE_ADDR, 0: byte address of word 0; must be aligned to DATA_W/8.
- READ_LAT, 1: request-accept to response cycles; 1 or 2.
- INIT_FILE, "": hex file loaded by $readmemh at elaboration; empty string means no load.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DATA_W  store data, right-aligned (bits [8*n-1:0] used).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_W  load data, right-aligned and extended; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, illegal size, or out of range.

## Operation
- Off = req_addr - BASE_ADDR; word index = Off / (DATA_W/8); lane = Off mod (DATA_W/8). Byte order is little-endian.
- Error conditions are checked at accept time:
  - Off is not a multiple of 2^req_size.
  - Off >= DEPTH*DATA_W/8, including req_addr < BASE_ADDR through wrap-around of the subtraction.
  - req_size=11 with DATA_W=32.
- An errored request writes nothing and produces rsp_err=1 with rsp_rdata=0.
- Store: on the accept edge, write only the 2^req_size bytes starting at lane. The bytes come from req_wdata low bits. Other bytes are unchanged. The response is an ack with rsp_rdata=0 and rsp_err=0.
- Load: read the RAM word at the accept edge. Extract the 2^req_size bytes at lane, shift them to bit 0, and sign- or zero-extend to DATA_W per req_unsigned.
- Pipeline is READ_LAT stages, each holding {valid, err, data}. The last stage drives the rsp_* outputs.
- Advance = !last.valid | rsp_ready. All stages shift when advance=1 and hold when advance=0.
- req_ready = advance & rst_n. It is combinational from the last stage and rsp_ready. Requests are never dropped.
- Loads and stores complete in order. Throughput is one request per cycle when rsp_ready is held high.
- Read-after-write: a load accepted in the cycle after a store to the same bytes returns the stored data.
- Memory contents are not reset. INIT_FILE is the only initialisation.

## Timing
- Reset (rst_n=0, asynchronous): all stage valids = 0, so rsp_valid=0, rsp_err=0, rsp_rdata=0, and req_ready=0.
- req_ready=1 in the first cycle after rst_n deasserts.
- Reset mid-operation: in-flight responses are discarded. Stores already accepted remain in memory. A request offered during reset is not accepted.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N+READ_LAT-1, for the cycle ending at edge N+READ_LAT, provided rsp_ready=1 throughout.
- Backpressure:
  - With rsp_valid=1 and rsp_ready=0: rsp_* stay stable and req_ready=0.
  - With rsp_ready=1: a new request is accepted in the same cycle as the response handshake.
- A store commits at its accept edge, independent of when its ack is consumed.

## Test plan
- Reset, then preload word 0 = 0x8081_82F3 (DATA_W=32, READ_LAT=1, BASE_ADDR=0). Load byte addr 0 signed -> rsp_rdata=0xFFFF_FFF3. Load half addr 2 unsigned -> 0x0000_8081, rsp_err=0, one cycle after accept.
- Store byte 0xAB to addr 5, then load word addr 4 (old word 0x1122_3344) -> 0x1122_AB44. The load is issued back-to-back with the store, and the store ack has rsp_rdata=0.
- Load word addr 6 -> rsp_err=1, rdata=0. Store word addr 0x800 with DEPTH=512 -> rsp_err=1 and memory unchanged on a readback of every word. Size 11 with DATA_W=32 -> rsp_err=1.
- READ_LAT=2: issue 4 back-to-back loads with rsp_ready=1 -> 4 consecutive responses starting 2 cycles after the first accept. Drop rsp_ready for 3 cycles mid-stream -> req_ready=0 and rsp_* stable, no loss, order preserved.
- DATA_W=64: store double 0x0123_4567_89AB_CDEF at addr 8, then load word signed at addr 12 -> 0x0000_0000_0123_4567. Load half at addr 14 signed -> 0x0000_0000_0000_0123.
- Assert rst_n=0 with 2 responses in flight and rsp_ready=0 -> rsp_valid=0 immediately (asynchronous). After release, req_ready=1 and the earlier accepted store is still readable.

Source files
------------

// File: rtl/dmem_pipe.sv
// dmem_pipe: pipelined data memory for the LSU bus.
// Ready/valid request and response ports, byte/half/word(/double) accesses with
// byte-lane writes, READ_LAT response stages and error responses for misaligned,
// illegal-size or out-of-range requests. Memory contents are never reset.
module dmem_pipe #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 512,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                READ_LAT  = 1,
    parameter string             INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int                NB        = DATA_W / 8;
    localparam int                LANE_W    = $clog2(NB);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   MEM_BYTES = (ADDR_W + 1)'(DEPTH * NB);
    localparam int                LAST      = READ_LAT - 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] lane;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_size;
    logic              req_err;
    logic [NB-1:0]     size_mask;
    logic [NB-1:0]     byte_en;
    logic [DATA_W-1:0] wdata_shifted;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] keep_mask;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] stage_in_data;
    logic              sign_bit;
    logic              advance;
    logic              accept;
    logic              wr_en;

    logic [READ_LAT-1:0] stage_valid;
    logic [READ_LAT-1:0] stage_err;
    logic [DATA_W-1:0]   stage_data [READ_LAT];

    // The subtraction wraps for addresses below BASE_ADDR, which the range
    // check then rejects like any other address past the end of the array.
    assign off          = req_addr - BASE_ADDR;
    assign lane         = off[LANE_W-1:0];
    assign idx          = off[LANE_W +: IDX_W];
    assign out_of_range = ({1'b0, off} >= MEM_BYTES);
    assign bad_size     = (req_size == 2'b11) && (DATA_W == 32);
    assign req_err      = misaligned | out_of_range | bad_size;

    // The pipe moves whenever the output slot is empty or being drained, so a
    // new request can be taken in the same cycle as a response handshake.
    assign advance   = !stage_valid[LAST] | rsp_ready;
    assign req_ready = advance & rst_n;
    assign accept    = req_valid & req_ready;
    assign wr_en     = accept & req_we & !req_err;

    assign byte_en       = size_mask << lane;
    assign wdata_shifted = req_wdata << {lane, 3'b000};
    assign rd_word       = out_of_range ? '0 : mem[idx];
    assign rd_shifted    = rd_word >> {lane, 3'b000};
    assign stage_in_data = (req_we || req_err) ? '0 : load_data;

    assign rsp_valid = stage_valid[LAST];
    assign rsp_err   = stage_err[LAST];
    assign rsp_rdata = stage_data[LAST];

    // Alignment check: the offset must be a multiple of the access size.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            2'b11:   misaligned = |off[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Byte-lane mask for the access size, before shifting to the lane.
    always_comb begin
        size_mask = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < (1 << req_size)) size_mask[b] = 1'b1;
        end
    end

    // Load extraction: keep the accessed bytes, then sign- or zero-extend.
    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < (8 << req_size)) keep_mask[i] = 1'b1;
        end
        case (req_size)
            2'b00:   sign_bit = rd_shifted[7];
            2'b01:   sign_bit = rd_shifted[15];
            2'b10:   sign_bit = rd_shifted[31];
            default: sign_bit = rd_shifted[DATA_W-1];
        endcase
        load_data = rd_shifted & keep_mask;
        if (!req_unsigned && sign_bit) load_data = load_data | ~keep_mask;
    end

    // Store commit at the accept edge, touching only the addressed byte lanes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_shifted[8*b +: 8];
            end
        end
    end

    // Response pipeline: stage 0 captures the accepted request, later stages shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            stage_err   <= '0;
            for (int i = 0; i < READ_LAT; i++) stage_data[i] <= '0;
        end else if (advance) begin
            stage_valid[0] <= accept;
            stage_err[0]   <= accept & req_err;
            stage_data[0]  <= accept ? stage_in_data : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_err[i]   <= stage_err[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

endmodule
